// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag record.
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOT   = 4'd5,
      OP_SHL   = 4'd6,
      OP_SHR   = 4'd7,
      OP_ASR   = 4'd8,
      OP_ROL   = 4'd9,
      OP_ADC   = 4'd10,
      OP_SBC   = 4'd11,
      OP_CMP   = 4'd12,
      OP_MUL   = 4'd13,
      OP_ILL14 = 4'd14,
      OP_ILL15 = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } alu_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   function automatic logic is_shift(alu_op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative one-bit-per-cycle shifter/rotator and, with ALU_MUL_EN, a shift-add multiplier.
// done is combinational on the final step so the caller can capture res/carry on that edge.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  kind,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH + 1);

   alu_op_e          kind_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] val;
   logic [WIDTH-1:0] val_nxt;
   logic             c_nxt;

   always_comb begin
      val_nxt = val;
      c_nxt   = 1'b0;
      case (kind_q)
         OP_SHL: begin
            val_nxt = {val[WIDTH-2:0], 1'b0};
            c_nxt   = val[WIDTH-1];
         end
         OP_SHR: begin
            val_nxt = {1'b0, val[WIDTH-1:1]};
            c_nxt   = val[0];
         end
         OP_ASR: begin
            val_nxt = {val[WIDTH-1], val[WIDTH-1:1]};
            c_nxt   = val[0];
         end
         OP_ROL: begin
            val_nxt = {val[WIDTH-2:0], val[WIDTH-1]};
            c_nxt   = val[WIDTH-1];
         end
         default: ;
      endcase
   end

   assign done = busy && (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         val    <= '0;
         kind_q <= OP_ADD;
      end else if (start) begin
         busy   <= 1'b1;
         kind_q <= alu_op_e'(kind);
         val    <= a;
         cnt    <= (alu_op_e'(kind) == OP_MUL) ? CW'(WIDTH) : CW'(b[SHW-1:0]);
      end else if (busy) begin
         val <= val_nxt;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1))
            busy <= 1'b0;
      end
   end

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic               is_mul;

   assign is_mul  = (kind_q == OP_MUL);
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   assign res     = is_mul ? acc_nxt[WIDTH-1:0] : val_nxt;
   assign carry   = is_mul ? |acc_nxt[2*WIDTH-1:WIDTH] : c_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= acc_nxt;
         mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
         mplier <= {1'b0, mplier[WIDTH-1:1]};
      end
   end
`else
   logic unused_b;

   assign unused_b = ^b[WIDTH-1:SHW];
   assign res      = val_nxt;
   assign carry    = c_nxt;
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: FSM, single-cycle datapath and flag register.
// Define ALU_MUL_EN to enable the iterative multiply on opcode 13 (otherwise illegal).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             out_err
);

   localparam int M = WIDTH - 1;

   alu_state_e       state;
   alu_flags_t       flags_q;
   alu_op_e          op_e;
   logic             accept;
   logic             needs_iter;
   logic             iter_start;
   logic             iter_busy;
   logic             iter_done;
   logic [WIDTH-1:0] iter_res;
   logic             iter_c;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             cin;
   logic             add_v;
   logic             sub_v;
   logic [WIDTH-1:0] s_res;
   alu_flags_t       s_f;
   logic             s_err;
   alu_flags_t       i_f;

   assign op_e = alu_op_e'(op);

   // A finished result may be retired and a new op accepted on the same edge.
   assign in_ready   = (state != ST_EXEC) && !iter_busy && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
`ifdef ALU_MUL_EN
   assign needs_iter = (is_shift(op_e) && (b[SHW-1:0] != '0)) || (op_e == OP_MUL);
`else
   assign needs_iter = is_shift(op_e) && (b[SHW-1:0] != '0);
`endif
   assign iter_start = accept && needs_iter;

   always_comb begin
      cin   = ((op_e == OP_ADC) || (op_e == OP_SBC)) ? flags_q.c : 1'b0;
      sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      add_v = (a[M] == b[M]) && (sum[M] != a[M]);
      sub_v = (a[M] != b[M]) && (diff[M] != a[M]);
      s_res = '0;
      s_f   = '0;
      s_err = 1'b0;
      case (op_e)
         OP_ADD, OP_ADC: begin
            s_res = sum[M:0];
            s_f.c = sum[WIDTH];
            s_f.v = add_v;
         end
         OP_SUB, OP_SBC: begin
            s_res = diff[M:0];
            s_f.c = diff[WIDTH];
            s_f.v = sub_v;
         end
         OP_AND: s_res = a & b;
         OP_OR:  s_res = a | b;
         OP_XOR: s_res = a ^ b;
         OP_NOT: s_res = ~a;
         OP_SHL, OP_SHR, OP_ASR, OP_ROL: s_res = a;
         OP_CMP: begin
            s_res = a;
            s_f.c = diff[WIDTH];
            s_f.v = sub_v;
         end
`ifdef ALU_MUL_EN
         OP_MUL: ;
`endif
         default: s_err = 1'b1;
      endcase
      s_f.z = (s_res == '0);
      s_f.n = s_res[M];
      if (op_e == OP_CMP) begin
         s_f.z = (diff[M:0] == '0);
         s_f.n = diff[M];
      end
   end

   always_comb begin
      i_f   = '0;
      i_f.z = (iter_res == '0);
      i_f.n = iter_res[M];
      i_f.c = iter_c;
   end

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (iter_start),
      .kind  (op),
      .a     (a),
      .b     (b),
      .busy  (iter_busy),
      .done  (iter_done),
      .res   (iter_res),
      .carry (iter_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (needs_iter) begin
                     state     <= ST_EXEC;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     result    <= s_res;
                     flags_q   <= s_f;
                     out_err   <= s_err;
                  end
               end else if (out_valid && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (iter_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= iter_res;
                  flags_q   <= i_f;
                  out_err   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign flag_z = flags_q.z;
   assign flag_n = flags_q.n;
   assign flag_c = flags_q.c;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); honours ALU_MUL_EN for opcode 13.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         flag_z, flag_n, flag_c, flag_v;
   logic         out_err;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .out_err   (out_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [3:0]   f;   // {z,n,c,v}
      logic         err;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [W-1:0] r, input logic [3:0] f, input logic e,
                               input int l);
      vec_t v;
      v.op = o; v.a = va; v.b = vb; v.res = r; v.f = f; v.err = e; v.lat = l;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {flag_z, flag_n, flag_c, flag_v};
   endfunction

   task automatic wait_valid(input string tag, output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) chk({tag, "_timeout"}, out_valid, 1);
   endtask

   task automatic run(input vec_t v, input string tag);
      int lat;
      in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(tag, lat);
      chk({tag, "_lat"}, lat, v.lat);
      chk({tag, "_res"}, result, v.res);
      chk({tag, "_flags"}, flags(), v.f);
      chk({tag, "_err"}, out_err, v.err);
      @(posedge clk); #1;
      chk({tag, "_retired"}, out_valid, 0);
   endtask

   initial begin
      int stale;
      vec_t v;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;

      //   op     a      b      res    zncv     err lat
      add(4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101, 0, 1);
      add(4'd1,  8'h00, 8'h01, 8'hFF, 4'b0110, 0, 1);
      add(4'd10, 8'h01, 8'h01, 8'h03, 4'b0000, 0, 1);
      add(4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 1);
      add(4'd10, 8'h10, 8'h20, 8'h31, 4'b0000, 0, 1);
      add(4'd1,  8'h10, 8'h20, 8'hF0, 4'b0110, 0, 1);
      add(4'd11, 8'h05, 8'h05, 8'hFF, 4'b0110, 0, 1);
      add(4'd11, 8'h05, 8'h02, 8'h02, 4'b0000, 0, 1);
      add(4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 0, 1);
      add(4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 1);
      add(4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0100, 0, 1);
      add(4'd4,  8'hAA, 8'hAA, 8'h00, 4'b1000, 0, 1);
      add(4'd5,  8'h5A, 8'h00, 8'hA5, 4'b0100, 0, 1);
      add(4'd7,  8'h81, 8'h01, 8'h40, 4'b0010, 0, 2);
      add(4'd6,  8'h81, 8'h03, 8'h08, 4'b0000, 0, 4);
      add(4'd9,  8'h81, 8'h01, 8'h03, 4'b0010, 0, 2);
      add(4'd8,  8'h80, 8'h02, 8'hE0, 4'b0100, 0, 3);
      add(4'd6,  8'h55, 8'h00, 8'h55, 4'b0000, 0, 1);
      add(4'd6,  8'h01, 8'h09, 8'h02, 4'b0000, 0, 2);
      add(4'd9,  8'h80, 8'h07, 8'h40, 4'b0000, 0, 8);
      add(4'd12, 8'h05, 8'h05, 8'h05, 4'b1000, 0, 1);
      add(4'd12, 8'h03, 8'h05, 8'h03, 4'b0110, 0, 1);
      add(4'd14, 8'h12, 8'h34, 8'h00, 4'b1000, 1, 1);
      add(4'd15, 8'hFF, 8'hFF, 8'h00, 4'b1000, 1, 1);
`ifdef ALU_MUL_EN
      add(4'd13, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 0, 9);
      add(4'd13, 8'hFF, 8'h02, 8'hFE, 4'b0110, 0, 9);
`else
      add(4'd13, 8'h0D, 8'h0B, 8'h00, 4'b1000, 1, 1);
`endif
      add(4'd0,  8'h01, 8'h01, 8'h02, 4'b0000, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags(), 0);
      chk("rst_err", out_err, 0);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < vecs.size(); i++)
         run(vecs[i], $sformatf("v%0d", i));

      // Backpressure: hold the result, keep a new op pending until the retire cycle.
      out_ready = 1'b0;
      in_valid = 1'b1; op = 4'd0; a = 8'h12; b = 8'h34;
      @(posedge clk); #1;
      op = 4'd4; a = 8'hFF; b = 8'h0F;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_valid", k), out_valid, 1);
         chk($sformatf("bp%0d_res", k), result, 8'h46);
         chk($sformatf("bp%0d_flags", k), flags(), 4'b0000);
         chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_retire_in_ready", in_ready, 1);
      chk("bp_retire_res", result, 8'h46);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_res", result, 8'hF0);
      chk("bp_next_flags", flags(), 4'b0100);
      @(posedge clk); #1;
      chk("bp_drained", out_valid, 0);

      // Reset in the middle of a 7-cycle shift.
      in_valid = 1'b1; op = 4'd6; a = 8'h01; b = 8'h07;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      chk("mid_pre_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_flags", flags(), 0);
      chk("mid_rst_res", result, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      stale = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("mid_no_stale", stale, 0);

      // Carry cleared by reset: ADC must not add a stale C.
      v.op = 4'd10; v.a = 8'h01; v.b = 8'h01; v.res = 8'h02; v.f = 4'b0000; v.err = 0; v.lat = 1;
      run(v, "post_rst_adc");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
